// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_stage
//  Brief    : Two-entry skid buffer that registers ALU results, flags and
//             opcode tag, with sticky flag and accepted-result status.
//  Revision : 1.0  initial release
// ============================================================================

module alu_result_stage #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_out,
   input  logic             in_zero,
   input  logic             in_carry,
   input  logic             in_sign,
   input  logic             in_parity,
   input  logic             in_overflow,
   input  logic [1:0]       in_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [4:0]       out_flags,
   output logic [1:0]       out_select,
   output logic [4:0]       sticky_flags,
   output logic [CNT_W-1:0] result_cnt,
   input  logic             stat_clr
);

   localparam int c_FLAG_W = 5;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0]    r_m_data, r_s_data;
   logic [c_FLAG_W-1:0] r_m_flags, r_s_flags;
   logic [1:0]          r_m_sel, r_s_sel;
   logic [c_FLAG_W-1:0] r_sticky;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_accept;
   logic                w_pop;
   logic [c_FLAG_W-1:0] w_in_flags;
   logic                w_load_m_in;
   logic                w_load_m_s;
   logic                w_load_s;

   // Handshake outputs decode only the state register, so neither side sees a
   // combinational path from the other.
   assign in_ready   = (r_state != ST_FULL);
   assign out_valid  = (r_state != ST_EMPTY);
   assign w_accept   = in_valid & in_ready;
   assign w_pop      = out_valid & out_ready;
   assign w_in_flags = {in_overflow, in_parity, in_sign, in_carry, in_zero};

   always_comb begin
      w_state_nxt = r_state;
      w_load_m_in = 1'b0;
      w_load_m_s  = 1'b0;
      w_load_s    = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_ONE;
               w_load_m_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && !w_pop) begin
               w_state_nxt = ST_FULL;
               w_load_s    = 1'b1;
            end else if (w_pop && !w_accept) begin
               w_state_nxt = ST_EMPTY;
            end else if (w_accept && w_pop) begin
               w_load_m_in = 1'b1;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_state_nxt = ST_ONE;
               w_load_m_s  = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_data  <= '0;
         r_m_flags <= '0;
         r_m_sel   <= '0;
         r_s_data  <= '0;
         r_s_flags <= '0;
         r_s_sel   <= '0;
      end else begin
         if (w_load_m_in) begin
            r_m_data  <= in_out;
            r_m_flags <= w_in_flags;
            r_m_sel   <= in_select;
         end else if (w_load_m_s) begin
            r_m_data  <= r_s_data;
            r_m_flags <= r_s_flags;
            r_m_sel   <= r_s_sel;
         end
         if (w_load_s) begin
            r_s_data  <= in_out;
            r_s_flags <= w_in_flags;
            r_s_sel   <= in_select;
         end
      end
   end

   // A clear coinciding with an accept restarts the statistics from that result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= '0;
         r_cnt    <= '0;
      end else if (stat_clr) begin
         r_sticky <= w_accept ? w_in_flags : '0;
         r_cnt    <= w_accept ? CNT_W'(1) : '0;
      end else if (w_accept) begin
         r_sticky <= r_sticky | w_in_flags;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   assign out_data     = r_m_data;
   assign out_flags    = r_m_flags;
   assign out_select   = r_m_sel;
   assign sticky_flags = r_sticky;
   assign result_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_stage
//  Brief    : Directed self-checking bench for alu_result_stage.
//  Revision : 1.0  initial release
// ============================================================================

module tb_alu_result_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_out;
   logic       in_zero, in_carry, in_sign, in_parity, in_overflow;
   logic [1:0] in_select;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [4:0] out_flags;
   logic [1:0] out_select;
   logic [4:0] sticky_flags;
   logic [7:0] result_cnt;
   logic       stat_clr;

   int checks = 0;
   int errors = 0;

   alu_result_stage #(.WIDTH(4), .CNT_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_out       (in_out),
      .in_zero      (in_zero),
      .in_carry     (in_carry),
      .in_sign      (in_sign),
      .in_parity    (in_parity),
      .in_overflow  (in_overflow),
      .in_select    (in_select),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_flags    (out_flags),
      .out_select   (out_select),
      .sticky_flags (sticky_flags),
      .result_cnt   (result_cnt),
      .stat_clr     (stat_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // flags order {ov, par, sign, carry, zero}
   task automatic drive(input logic v, input logic [3:0] d, input logic [4:0] f, input logic [1:0] s);
      in_valid    = v;
      in_out      = d;
      in_zero     = f[0];
      in_carry    = f[1];
      in_sign     = f[2];
      in_parity   = f[3];
      in_overflow = f[4];
      in_select   = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] r;
      logic [10:0] prev;

      rst_n     = 1'b0;
      out_ready = 1'b0;
      stat_clr  = 1'b0;
      drive(1'b0, 4'h0, 5'h00, 2'b00);
      #3;
      check("rst_in_ready",  in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data, 0);
      check("rst_out_flags", out_flags, 0);
      check("rst_out_sel",   out_select, 0);
      check("rst_sticky",    sticky_flags, 0);
      check("rst_cnt",       result_cnt, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // single transfer
      out_ready = 1'b1;
      drive(1'b1, 4'b1010, 5'b10100, 2'b01);
      tick();
      drive(1'b0, 4'h0, 5'h00, 2'b00);
      check("single_valid",  out_valid, 1);
      check("single_data",   out_data, 4'b1010);
      check("single_flags",  out_flags, 5'b10100);
      check("single_sel",    out_select, 2'b01);
      check("single_cnt",    result_cnt, 1);
      check("single_sticky", sticky_flags, 5'b10100);
      tick();
      check("single_drain", out_valid, 0);

      // back-pressure
      clear_stats();
      out_ready = 1'b0;
      drive(1'b1, 4'b0001, 5'b00000, 2'b10);
      tick();
      check("bp_ready_one", in_ready, 1);
      check("bp_valid_one", out_valid, 1);
      drive(1'b1, 4'b0010, 5'b00001, 2'b11);
      tick();
      check("bp_ready_full", in_ready, 0);
      check("bp_data_full",  out_data, 4'b0001);
      drive(1'b1, 4'b1111, 5'b11111, 2'b00);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_stall_data",  out_data, 4'b0001);
         check("bp_stall_sel",   out_select, 2'b10);
         check("bp_stall_ready", in_ready, 0);
      end
      check("bp_cnt", result_cnt, 2);
      drive(1'b0, 4'h0, 5'h00, 2'b00);
      out_ready = 1'b1;
      tick();
      check("bp_pop2_data",  out_data, 4'b0010);
      check("bp_pop2_flags", out_flags, 5'b00001);
      check("bp_pop2_ready", in_ready, 1);
      tick();
      check("bp_empty", out_valid, 0);

      // streaming
      clear_stats();
      prev = '0;
      for (int i = 0; i < 200; i++) begin
         r = 11'($urandom);
         drive(1'b1, r[3:0], r[8:4], r[10:9]);
         tick();
         check("stream_ready", in_ready, 1);
         check("stream_valid", out_valid, 1);
         check("stream_payload", {out_select, out_flags, out_data}, r);
         if (i > 0) check("stream_not_prev", ({out_select, out_flags, out_data} == prev) && (r != prev), 0);
         prev = r;
      end
      drive(1'b0, 4'h0, 5'h00, 2'b00);
      check("stream_cnt", result_cnt, 200);
      tick();

      // sticky and clear
      clear_stats();
      drive(1'b1, 4'h0, 5'b00001, 2'b00);
      tick();
      drive(1'b1, 4'h3, 5'b00010, 2'b01);
      tick();
      check("sticky_or",     sticky_flags, 5'b00011);
      check("sticky_cnt2",   result_cnt, 2);
      drive(1'b1, 4'h8, 5'b10000, 2'b10);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      drive(1'b0, 4'h0, 5'h00, 2'b00);
      check("clracc_sticky", sticky_flags, 5'b10000);
      check("clracc_cnt",    result_cnt, 1);
      clear_stats();
      check("clr_sticky",    sticky_flags, 0);
      check("clr_cnt",       result_cnt, 0);
      tick();

      // counter wrap
      clear_stats();
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 4'(i), 5'h00, 2'b00);
         tick();
         if (i == 254) check("wrap_255", result_cnt, 255);
      end
      drive(1'b0, 4'h0, 5'h00, 2'b00);
      check("wrap_0", result_cnt, 0);
      tick();

      // async reset while full
      out_ready = 1'b0;
      drive(1'b1, 4'b1100, 5'b00100, 2'b01);
      tick();
      drive(1'b1, 4'b1101, 5'b01000, 2'b10);
      tick();
      drive(1'b0, 4'h0, 5'h00, 2'b00);
      check("arst_full", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready",  in_ready, 1);
      check("arst_data",      out_data, 0);
      check("arst_cnt",       result_cnt, 0);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 4'b0111, 5'b00011, 2'b11);
      tick();
      drive(1'b0, 4'h0, 5'h00, 2'b00);
      check("arst_first_valid", out_valid, 1);
      check("arst_first_data",  out_data, 4'b0111);
      check("arst_first_sel",   out_select, 2'b11);
      tick();
      check("arst_no_old", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 4-bit ALU (a, b, select -> out, zero, carry, sign, parity, overflow).
- Captures each ALU result, its five flags and the opcode tag into a 2-entry skid buffer with valid/ready handshake on both sides, so a stalled consumer never drops a result.
- Also keeps sticky (OR-accumulated) flags and a count of accepted results for status readback.

Parameters:
- WIDTH, 4, ALU data width (matches ALU out).
- CNT_W, 8, width of the accepted-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept this cycle.
- in_out  input  WIDTH  ALU out.
- in_zero  input  1  ALU zero flag.
- in_carry  input  1  ALU carry flag.
- in_sign  input  1  ALU sign flag.
- in_parity  input  1  ALU parity flag.
- in_overflow  input  1  ALU overflow flag.
- in_select  input  2  opcode that produced the result (tag).
- out_valid  output  1  out_* holds a valid entry.
- out_ready  input  1  consumer takes entry this cycle.
- out_data  output  WIDTH  registered result.
- out_flags  output  5  {overflow, parity, sign, carry, zero}; bit0 = zero.
- out_select  output  2  registered opcode tag.
- sticky_flags  output  5  OR of flags of all results accepted since reset or last clear; same bit order.
- result_cnt  output  CNT_W  number of accepted results, modulo 2^CNT_W.
- stat_clr  input  1  synchronous clear of sticky_flags and result_cnt.

Behaviour:
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Two entry registers: M (drives out_*) and S (skid).
- State register: EMPTY, ONE, FULL.
- Combinational decodes of the state register (no combinational path from in_valid or out_ready):
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: accept -> ONE, M <= in. Otherwise stay.
  - ONE: accept & !pop -> FULL, S <= in. pop & !accept -> EMPTY. accept & pop -> ONE, M <= in. Neither -> ONE, hold.
  - FULL: pop -> ONE, M <= S. Otherwise hold. No accept is possible.
- Latency: result accepted at edge N appears on out_* with out_valid=1 after edge N (1 cycle) when EMPTY, or when ONE with a simultaneous pop.
- Ordering: strict FIFO; no entry dropped or duplicated.
- Stability: while out_valid & !out_ready, out_data, out_flags and out_select must not change.
- Sticky flags and counter, evaluated per edge:
  - stat_clr & accept: sticky <= in flags; cnt <= 1.
  - stat_clr only: sticky <= 0; cnt <= 0.
  - accept only: sticky <= sticky | in flags; cnt <= cnt + 1, wrapping 2^CNT_W-1 -> 0.
- Reset (async, any time including mid-transfer):
  - state = EMPTY, in_ready = 1, out_valid = 0.
  - out_data, out_flags, out_select, sticky_flags and result_cnt all 0.
  - M and S contents are discarded.
- Payload values when out_valid = 0 are don't-care after the first accept; the bench must not check them.
- in_* values are ignored unless accept.

Test Plan:
- Reset then single transfer, out_ready=1: in_out=4'b1010, flags {ov=1,par=0,sign=1,carry=0,zero=0}, select=2'b01 -> next cycle out_valid=1, out_data=1010, out_flags=5'b10100, out_select=01; result_cnt=1; sticky_flags=5'b10100.
- Back-pressure: out_ready=0, push A=0001 then B=0010 -> in_ready=0 after second accept (FULL); out_data holds 0001 for 5 stalled cycles; raise out_ready -> 0001 then 0010 popped in consecutive cycles, in_ready=1 again.
- Streaming: in_valid=1 and out_ready=1 for 200 random ALU results -> in_ready never drops; outputs equal inputs delayed 1 cycle, in order; result_cnt=200 mod 256=200.
- Sticky and clear: accept zero=1, then carry=1 -> sticky=5'b00011; stat_clr together with an accept carrying overflow=1 -> sticky=5'b10000, result_cnt=1; stat_clr alone -> 0, 0.
- Counter wrap, CNT_W=8: 256 accepts -> result_cnt=0.
- Async reset while FULL: assert rst_n=0 mid-cycle -> out_valid=0 and in_ready=1 immediately, without a clock edge; after release, next accept of 0111 is the first entry out; the old entries never appear.
